wolfram_ca_engine: RTL and testbench
====================================

WOLFRAM_CA_ENGINE -- requirements
Module: wolfram_ca_engine

Interface
REQ-001 SHALL have parameter N_CELLS, default 16, giving the automaton width in cells (minimum 3).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the run and generation counters.
REQ-003 SHALL have parameter DEFAULT_RULE, default 8'hB5, giving the rule loaded at reset.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port rule_in  input  8  new rule truth table.
REQ-007 SHALL have port rule_we  input  1  rule write strobe.
REQ-008 SHALL have port wrap_mode  input  1  boundary select: 1 = cyclic, 0 = fixed-zero.
REQ-009 SHALL have port load_valid  input  1  seed-load request.
REQ-010 SHALL have port load_data  input  N_CELLS  seed pattern.
REQ-011 SHALL have port load_ready  output  1  seed load accepted when high.
REQ-012 SHALL have port start  input  1  begin a run.
REQ-013 SHALL have port run_count  input  CNT_W  number of generations to compute.
REQ-014 SHALL have port step_en  input  1  pause control; the run advances only while high.
REQ-015 SHALL have port busy  output  1  run in progress.
REQ-016 SHALL have port done  output  1  one-cycle run-complete pulse.
REQ-017 SHALL have port cells  output  N_CELLS  current generation, registered.
REQ-018 SHALL have port gen_count  output  CNT_W  generations computed since the last load or reset.

Function
REQ-019 SHALL compute each next cell i as rule[7 - {L,C,R}], with C = cells[i], L = cells[i+1], R = cells[i-1]; so rule 8'hB5 maps 000->1, 001->0, 011->1, 100->0.
REQ-020 SHALL set the neighbours beyond the ends as follows: wrap_mode=1 makes L of the MSB cell cells[0] and R of cell 0 cells[N_CELLS-1]; wrap_mode=0 makes both 0. wrap_mode is sampled on every generation.
REQ-021 SHALL update all cells simultaneously from the previous generation.
REQ-022 SHALL use a two-state FSM, IDLE and RUN; busy = (state == RUN).
REQ-023 SHALL drive load_ready = ~busy; load_valid && load_ready SHALL write load_data to cells, clear gen_count, and leave the state IDLE.
REQ-024 SHALL, on rule_we in IDLE, latch rule_in for later generations; rule_we while busy SHALL be ignored.
REQ-025 SHALL, on start in IDLE with run_count > 0 and no load, latch run_count into a remaining counter and go to RUN.
REQ-026 SHALL, in RUN, compute one generation per edge with step_en=1: decrement remaining, increment gen_count (saturating at all-ones). An edge with step_en=0 SHALL hold everything.
REQ-027 SHALL, at the edge computing the final generation, return to IDLE and register done=1 for exactly that following cycle. A run of K with step_en held high therefore shows busy high K cycles and done in cycle K+1 after the start edge.
REQ-028 SHALL treat start in IDLE with run_count = 0 as no transition; done pulses the next cycle and the cells are unchanged.
REQ-029 SHALL give load priority over start when both are asserted in IDLE; the start is dropped.
REQ-030 SHALL ignore start, load_valid and rule_we while busy.

Reset
REQ-031 SHALL, on rst, set cells=0, gen_count=0, remaining=0, rule=DEFAULT_RULE, state=IDLE, busy=0, done=0, load_ready=1.
REQ-032 SHALL let rst asserted mid-run abort the run immediately, with no done pulse; rst overrides all other inputs in the same cycle.

Verification
REQ-033 SHALL cover: N_CELLS=8, default rule, wrap=1, load 8'h01, start run_count=1 -> cells=8'h7D, gen_count=1, done one cycle after busy falls.
REQ-034 SHALL cover: the same with wrap=0 -> cells=8'hFD; and load 8'h10 in either mode -> 8'hD7.
REQ-035 SHALL cover: rule_we 8'h00, load 8'hA5, run_count=3 -> busy high 3 cycles, cells=8'h00, gen_count=3, a single done pulse.
REQ-036 SHALL cover: run_count=4 with step_en low for 2 cycles mid-run -> busy high 6 cycles, gen_count=4; start, load and rule_we during the run have no effect.
REQ-037 SHALL cover: rst during a run of 10 after 3 generations -> next cycle cells=0, busy=0, no done, rule=8'hB5.
REQ-038 SHALL cover: load_valid and start together in IDLE -> cells=load_data, busy stays 0; start with run_count=0 -> done pulse, cells unchanged.

Source files
------------

// File: rtl/wolfram_ca_engine.sv
// One-dimensional elementary cellular automaton engine.
// Runs a programmable number of generations of an 8-bit Wolfram rule.
module wolfram_ca_engine #(
    parameter int         N_CELLS      = 16,
    parameter int         CNT_W        = 16,
    parameter logic [7:0] DEFAULT_RULE = 8'hB5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rule_in,
    input  logic               rule_we,
    input  logic               wrap_mode,
    input  logic               load_valid,
    input  logic [N_CELLS-1:0] load_data,
    output logic               load_ready,
    input  logic               start,
    input  logic [CNT_W-1:0]   run_count,
    input  logic               step_en,
    output logic               busy,
    output logic               done,
    output logic [N_CELLS-1:0] cells,
    output logic [CNT_W-1:0]   gen_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_CELLS-1:0] cells_q, cells_d;
    logic [CNT_W-1:0]   gen_q, gen_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [7:0]         rule_q, rule_d;
    logic               done_q, done_d;

    logic [N_CELLS+1:0] ext;
    logic [N_CELLS-1:0] next_gen;
    logic               left_edge;
    logic               right_edge;

    // Boundary neighbours wrap around or read as zero.
    assign left_edge  = wrap_mode & cells_q[0];
    assign right_edge = wrap_mode & cells_q[N_CELLS-1];
    assign ext        = {left_edge, cells_q, right_edge};

    always_comb begin
        next_gen = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            next_gen[i] = rule_q[3'd7 - {ext[i+2], ext[i+1], ext[i]}];
        end
    end

    always_comb begin
        state_d = state_q;
        cells_d = cells_q;
        gen_d   = gen_q;
        rem_d   = rem_q;
        rule_d  = rule_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rule_we) begin
                    rule_d = rule_in;
                end
                if (load_valid) begin
                    cells_d = load_data;
                    gen_d   = '0;
                end else if (start) begin
                    if (run_count != '0) begin
                        rem_d   = run_count;
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (step_en) begin
                    cells_d = next_gen;
                    rem_d   = rem_q - CNT_W'(1);
                    if (gen_q != '1) begin
                        gen_d = gen_q + CNT_W'(1);
                    end
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cells_q <= '0;
            gen_q   <= '0;
            rem_q   <= '0;
            rule_q  <= DEFAULT_RULE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cells_q <= cells_d;
            gen_q   <= gen_d;
            rem_q   <= rem_d;
            rule_q  <= rule_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign load_ready = ~busy;
    assign done       = done_q;
    assign cells      = cells_q;
    assign gen_count  = gen_q;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Directed and randomized checks of wolfram_ca_engine against a
// rule-table reference model on an 8-cell automaton.
module tb_wolfram_ca_engine;

    localparam int N     = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [7:0]       rule_in;
    logic             rule_we;
    logic             wrap_mode;
    logic             load_valid;
    logic [N-1:0]     load_data;
    logic             load_ready;
    logic             start;
    logic [CNT_W-1:0] run_count;
    logic             step_en;
    logic             busy;
    logic             done;
    logic [N-1:0]     cells;
    logic [CNT_W-1:0] gen_count;

    int vectors = 0;
    int errs    = 0;

    logic [7:0] mdl_cells;
    logic [7:0] mdl_rule;
    int         mdl_gen;

    wolfram_ca_engine #(
        .N_CELLS(N),
        .CNT_W(CNT_W),
        .DEFAULT_RULE(8'hB5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rule_in(rule_in),
        .rule_we(rule_we),
        .wrap_mode(wrap_mode),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .start(start),
        .run_count(run_count),
        .step_en(step_en),
        .busy(busy),
        .done(done),
        .cells(cells),
        .gen_count(gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Neighbourhood value n = 4L+2C+R selects truth-table bit 7-n.
    function automatic logic [7:0] ref_next(input logic [7:0] c,
                                            input logic [7:0] rule,
                                            input bit wrap);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            int l, m, r, idx;
            m = int'(c[i]);
            l = (i == 7 && !wrap) ? 0 : int'(c[(i + 1) % 8]);
            r = (i == 0 && !wrap) ? 0 : int'(c[(i + 7) % 8]);
            idx = 4 * l + 2 * m + r;
            n[i] = rule[7 - idx];
        end
        return n;
    endfunction

    task automatic do_load(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick;
        load_valid = 1'b0;
        mdl_cells  = d;
        mdl_gen    = 0;
    endtask

    task automatic set_rule(input logic [7:0] r);
        rule_we = 1'b1;
        rule_in = r;
        tick;
        rule_we  = 1'b0;
        mdl_rule = r;
    endtask

    task automatic do_run(input int k, input logic [31:0] pmask,
                          input bit disturb, input string tag);
        int cyc, pauses, bad;
        start     = 1'b1;
        run_count = CNT_W'(k);
        step_en   = 1'b1;
        tick;
        start = 1'b0;
        if (k == 0) begin
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_done"}, done, 1);
            chk({tag, "_cells"}, cells, mdl_cells);
            chk({tag, "_gen"}, gen_count, mdl_gen);
            tick;
            chk({tag, "_done_clr"}, done, 0);
            return;
        end
        chk({tag, "_busy_rise"}, busy, 1);
        cyc    = 0;
        pauses = 0;
        bad    = 0;
        while (busy && cyc < k + 40) begin
            if (done || load_ready) bad++;
            step_en = ~pmask[cyc % 32];
            if (!step_en) pauses++;
            if (disturb) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_data  = 8'hFF;
                rule_we    = 1'b1;
                rule_in    = 8'($urandom);
            end
            tick;
            cyc++;
        end
        start      = 1'b0;
        load_valid = 1'b0;
        rule_we    = 1'b0;
        step_en    = 1'b1;
        for (int j = 0; j < k; j++) begin
            mdl_cells = ref_next(mdl_cells, mdl_rule, wrap_mode);
        end
        mdl_gen = (mdl_gen + k > 255) ? 255 : mdl_gen + k;
        chk({tag, "_end"}, busy, 0);
        chk({tag, "_busy_cycles"}, cyc, k + pauses);
        chk({tag, "_midrun"}, bad, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_cells"}, cells, mdl_cells);
        chk({tag, "_gen"}, gen_count, mdl_gen);
        tick;
        chk({tag, "_done_clr"}, done, 0);
    endtask

    initial begin
        rst        = 1'b1;
        rule_in    = '0;
        rule_we    = 1'b0;
        wrap_mode  = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        run_count  = '0;
        step_en    = 1'b1;
        mdl_cells  = '0;
        mdl_rule   = 8'hB5;
        mdl_gen    = 0;
        tick;
        tick;
        chk("rst_cells", cells, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", load_ready, 1);
        rst = 1'b0;
        tick;

        wrap_mode = 1'b1;
        do_load(8'h01);
        chk("load01", cells, 8'h01);
        do_run(1, 32'h0, 1'b0, "w1_01");
        chk("w1_01_const", cells, 8'h7D);

        wrap_mode = 1'b0;
        do_load(8'h01);
        do_run(1, 32'h0, 1'b0, "w0_01");
        chk("w0_01_const", cells, 8'hFD);
        do_load(8'h10);
        do_run(1, 32'h0, 1'b0, "w0_10");
        chk("w0_10_const", cells, 8'hD7);
        wrap_mode = 1'b1;
        do_load(8'h10);
        do_run(1, 32'h0, 1'b0, "w1_10");
        chk("w1_10_const", cells, 8'hD7);

        set_rule(8'h00);
        do_load(8'hA5);
        do_run(3, 32'h0, 1'b0, "r00");
        chk("r00_const", cells, 8'h00);
        chk("r00_gen_const", gen_count, 3);

        set_rule(8'h1E);
        do_load(8'h3C);
        do_run(4, 32'h0000_0006, 1'b1, "pause");
        chk("pause_gen_const", gen_count, 4);

        do_load(8'h81);
        start     = 1'b1;
        run_count = 8'd10;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        chk("abort_gen3", gen_count, 3);
        chk("abort_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_cells", cells, 0);
        chk("abort_busy0", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_gen0", gen_count, 0);
        tick;
        chk("abort_done2", done, 0);
        mdl_rule  = 8'hB5;
        mdl_cells = '0;
        mdl_gen   = 0;
        wrap_mode = 1'b1;
        do_load(8'h01);
        do_run(1, 32'h0, 1'b0, "rule_rst");
        chk("rule_rst_const", cells, 8'h7D);

        load_valid = 1'b1;
        load_data  = 8'h5A;
        start      = 1'b1;
        run_count  = 8'd5;
        tick;
        load_valid = 1'b0;
        start      = 1'b0;
        mdl_cells  = 8'h5A;
        mdl_gen    = 0;
        chk("ld_st_cells", cells, 8'h5A);
        chk("ld_st_busy", busy, 0);
        tick;
        chk("ld_st_busy2", busy, 0);
        chk("ld_st_done", done, 0);
        do_run(0, 32'h0, 1'b0, "zero");

        do_load(8'h01);
        do_run(250, 32'h0, 1'b0, "sat_a");
        do_run(10, 32'h0, 1'b0, "sat_b");
        chk("sat_const", gen_count, 255);

        for (int t = 0; t < 24; t++) begin
            int k;
            set_rule(8'($urandom));
            wrap_mode = 1'($urandom);
            if ($urandom_range(0, 3) != 0) do_load(8'($urandom));
            k = $urandom_range(1, 20);
            do_run(k, $urandom & $urandom & $urandom,
                   1'($urandom), $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
